// File: rtl/flag_branch_unit.sv
// Flag register with same-cycle forwarding and a one-cycle branch resolver.
// Taken branches raise a registered redirect pulse that also squashes the next decode slot.
module flag_branch_unit #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              alu_valid,
  input  logic [3:0]        alu_op,
  input  logic              z_in,
  input  logic              n_in,
  input  logic              v_in,
  input  logic              br_valid,
  input  logic [2:0]        br_ccc,
  input  logic              br_is_reg,
  input  logic [8:0]        br_imm,
  input  logic [DATA_W-1:0] br_rs,
  input  logic [DATA_W-1:0] pc_plus2,
  output logic [2:0]        flags,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc
);

  logic              z_p1, v_p1, n_p1;
  logic              redirect_p1;
  logic              squash_p1;
  logic [DATA_W-1:0] redirect_pc_p1;

  logic              wr_all_p0, wr_z_p0;
  logic              z_p0, v_p0, n_p0;
  logic              vld_p0;
  logic              taken_p0;
  logic [DATA_W-1:0] target_p0;

  function automatic logic cond_eval(input logic [2:0] ccc, input logic z,
                                     input logic v, input logic n);
    logic r;
    case (ccc)
      3'b000:  r = ~z;
      3'b001:  r = z;
      3'b010:  r = ~z & ~n;
      3'b011:  r = n;
      3'b100:  r = z | ~n;
      3'b101:  r = n | z;
      3'b110:  r = v;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Word offset doubled to a byte offset; the add wraps silently.
  function automatic logic [DATA_W-1:0] rel_target(input logic [DATA_W-1:0] base,
                                                   input logic [8:0] imm);
    logic signed [DATA_W-1:0] off;
    off = {{(DATA_W-10){imm[8]}}, imm, 1'b0};
    return base + $unsigned(off);
  endfunction

  // Stage p0: flag write decode, forwarding, condition and target
  always_comb begin
    wr_all_p0 = 1'b0;
    wr_z_p0   = 1'b0;
    if (alu_valid && !stall) begin
      case (alu_op)
        4'b0000, 4'b0001: begin
          wr_all_p0 = 1'b1;
          wr_z_p0   = 1'b1;
        end
        4'b0010, 4'b0100, 4'b0101, 4'b0110: wr_z_p0 = 1'b1;
        default: ;
      endcase
    end
  end

  assign z_p0      = wr_z_p0   ? z_in : z_p1;
  assign v_p0      = wr_all_p0 ? v_in : v_p1;
  assign n_p0      = wr_all_p0 ? n_in : n_p1;
  assign vld_p0    = br_valid && !stall && !squash_p1;
  assign taken_p0  = vld_p0 && cond_eval(br_ccc, z_p0, v_p0, n_p0);
  assign target_p0 = br_is_reg ? br_rs : rel_target(pc_plus2, br_imm);

  // Stage p1: architectural flags and redirect outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      z_p1           <= 1'b0;
      v_p1           <= 1'b0;
      n_p1           <= 1'b0;
      redirect_p1    <= 1'b0;
      squash_p1      <= 1'b0;
      redirect_pc_p1 <= '0;
    end else if (!stall) begin
      z_p1        <= z_p0;
      v_p1        <= v_p0;
      n_p1        <= n_p0;
      redirect_p1 <= taken_p0;
      squash_p1   <= taken_p0;
      if (taken_p0)
        redirect_pc_p1 <= target_p0;
    end
  end

  assign flags       = {z_p1, v_p1, n_p1};
  assign redirect    = redirect_p1;
  assign redirect_pc = redirect_pc_p1;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit; flags are read as {Z, V, N}.
module tb_flag_branch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, alu_valid;
  logic [3:0]  alu_op;
  logic        z_in, n_in, v_in;
  logic        br_valid;
  logic [2:0]  br_ccc;
  logic        br_is_reg;
  logic [8:0]  br_imm;
  logic [15:0] br_rs, pc_plus2;
  logic [2:0]  flags;
  logic        redirect;
  logic [15:0] redirect_pc;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_rpc;

  always #5 clk = ~clk;

  flag_branch_unit #(.DATA_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .alu_valid(alu_valid), .alu_op(alu_op),
    .z_in(z_in), .n_in(n_in), .v_in(v_in), .br_valid(br_valid), .br_ccc(br_ccc),
    .br_is_reg(br_is_reg), .br_imm(br_imm), .br_rs(br_rs), .pc_plus2(pc_plus2),
    .flags(flags), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    br_valid  = 1'b0;
    alu_valid = 1'b0;
    stall     = 1'b0;
  endtask

  task automatic alu(input logic [3:0] op, input logic z, input logic n, input logic v);
    alu_valid = 1'b1;
    alu_op    = op;
    z_in      = z;
    n_in      = n;
    v_in      = v;
  endtask

  task automatic check_out(input string tag, input logic [2:0] f, input logic r,
                           input logic [15:0] pc);
    check_val({tag, "_flags"}, 16'(flags), 16'(f));
    check_val({tag, "_redirect"}, 16'(redirect), 16'(r));
    check_val({tag, "_pc"}, redirect_pc, pc);
  endtask

  // mask bit c = expected taken result for condition code c
  task automatic cond_sweep(input string tag, input logic [7:0] mask, input logic [2:0] f);
    for (int c = 0; c < 8; c++) begin
      br_valid  = 1'b1;
      br_is_reg = 1'b1;
      br_ccc    = 3'(c);
      br_rs     = 16'h1000 + 16'(c);
      step();
      if (mask[c]) exp_rpc = 16'h1000 + 16'(c);
      check_out($sformatf("%s_ccc%0d", tag, c), f, mask[c], exp_rpc);
      br_valid = 1'b0;
      step();
      check_val($sformatf("%s_ccc%0d_clear", tag, c), 16'(redirect), 16'h0);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; alu_valid = 1'b0; alu_op = 4'h0;
    z_in = 1'b0; n_in = 1'b0; v_in = 1'b0;
    br_valid = 1'b0; br_ccc = 3'b0; br_is_reg = 1'b0; br_imm = 9'h0;
    br_rs = 16'h0; pc_plus2 = 16'h0; exp_rpc = 16'h0;
    step();
    step();
    check_out("reset", 3'b000, 1'b0, 16'h0000);
    rst = 1'b0;

    // Flag update per opcode class
    alu(4'b0001, 1'b1, 1'b0, 1'b1);  step(); check_val("op0001", 16'(flags), 16'(3'b110));
    alu(4'b0010, 1'b0, 1'b1, 1'b0);  step(); check_val("op0010", 16'(flags), 16'(3'b010));
    alu(4'b0011, 1'b1, 1'b1, 1'b1);  step(); check_val("op0011", 16'(flags), 16'(3'b010));
    alu(4'b0000, 1'b0, 1'b1, 1'b0);  step(); check_val("op0000", 16'(flags), 16'(3'b001));
    alu(4'b1000, 1'b1, 1'b0, 1'b1);  step(); check_val("op1000", 16'(flags), 16'(3'b001));
    alu(4'b0110, 1'b1, 1'b0, 1'b1);  step(); check_val("op0110", 16'(flags), 16'(3'b101));
    alu(4'b0111, 1'b0, 1'b0, 1'b0);  step(); check_val("op0111", 16'(flags), 16'(3'b101));
    alu(4'b0000, 1'b0, 1'b0, 1'b0);  alu_valid = 1'b0;
    step(); check_val("alu_invalid", 16'(flags), 16'(3'b101));

    // Conditions with Z=1 V=0 N=1, then Z=0 V=1 N=0
    cond_sweep("zn", 8'b1011_1010, 3'b101);
    alu(4'b0000, 1'b0, 1'b0, 1'b1);  step(); alu_valid = 1'b0;
    check_val("set_v", 16'(flags), 16'(3'b010));
    cond_sweep("v", 8'b1101_0101, 3'b010);

    // Same-cycle forwarding: ADD sets Z, EQ branch sees it
    alu(4'b0001, 1'b1, 1'b0, 1'b0);
    br_valid = 1'b1; br_ccc = 3'b001; br_is_reg = 1'b0;
    pc_plus2 = 16'h0010; br_imm = 9'h1FE;
    step(); exp_rpc = 16'h000C;
    check_out("fwd_eq", 3'b100, 1'b1, exp_rpc);
    idle(); step(); check_val("fwd_clear", 16'(redirect), 16'h0);
    alu(4'b0010, 1'b0, 1'b1, 1'b1);
    br_valid = 1'b1; br_ccc = 3'b001; br_is_reg = 1'b1; br_rs = 16'hDEAD;
    step();
    check_out("fwd_not_taken", 3'b000, 1'b0, exp_rpc);
    idle();

    // Target arithmetic: wrap, large negative offset, register target
    br_valid = 1'b1; br_ccc = 3'b111; br_is_reg = 1'b0;
    pc_plus2 = 16'hFFFE; br_imm = 9'h002;
    step(); check_val("wrap_pc", redirect_pc, 16'h0002);
    br_valid = 1'b0; step();
    br_valid = 1'b1; pc_plus2 = 16'h0000; br_imm = 9'h100;
    step(); check_val("neg_pc", redirect_pc, 16'hFE00);
    br_valid = 1'b0; step();
    br_valid = 1'b1; br_is_reg = 1'b1; br_rs = 16'h1234;
    step(); check_val("br_pc", redirect_pc, 16'h1234);
    br_valid = 1'b0; step();

    // Squash of the slot after a taken branch
    br_valid = 1'b1; br_ccc = 3'b111; br_is_reg = 1'b0;
    pc_plus2 = 16'h0100; br_imm = 9'h010;
    step(); check_out("sq_first", 3'b000, 1'b1, 16'h0120);
    br_is_reg = 1'b1; br_rs = 16'hBEEF;
    step(); check_out("sq_ignored", 3'b000, 1'b0, 16'h0120);
    step(); check_out("sq_after", 3'b000, 1'b1, 16'hBEEF);
    idle(); step();

    // Stall holds redirect, flags, target and squash
    alu(4'b0001, 1'b1, 1'b1, 1'b1);
    br_valid = 1'b1; br_ccc = 3'b111; br_is_reg = 1'b1; br_rs = 16'h5555;
    step(); check_out("st_branch", 3'b111, 1'b1, 16'h5555);
    alu(4'b0001, 1'b0, 1'b0, 1'b0);
    stall = 1'b1; br_rs = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("st_hold%0d", i), 3'b111, 1'b1, 16'h5555);
    end
    stall = 1'b0; alu_valid = 1'b0;
    step(); check_out("st_squash", 3'b111, 1'b0, 16'h5555);
    idle(); step();

    // Reset beats a concurrent branch and flag update
    alu(4'b0001, 1'b1, 1'b0, 1'b0);
    br_valid = 1'b1; br_ccc = 3'b111; br_is_reg = 1'b1; br_rs = 16'h9999;
    rst = 1'b1;
    step(); check_out("rst_mid", 3'b000, 1'b0, 16'h0000);
    rst = 1'b0; idle();

    // Reset beats stall with a redirect pending
    br_valid = 1'b1; br_ccc = 3'b111; br_is_reg = 1'b1; br_rs = 16'h4321;
    step(); check_out("rst_pre", 3'b000, 1'b1, 16'h4321);
    br_valid = 1'b0; stall = 1'b1; rst = 1'b1;
    step(); check_out("rst_stall", 3'b000, 1'b0, 16'h0000);
    rst = 1'b0; idle(); step();
    check_out("rst_end", 3'b000, 1'b0, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
